// File: rtl/signed_subtractor_pipe_if.sv
// ----------------------------------------------------------------------------
// signed_subtractor_pipe_if
// Purpose : groups the input handshake, output handshake and overflow status
//           of signed_subtractor_pipe into one bundle.
// Signals : in_valid/in_ready/a/b      - operand channel (producer -> block)
//           out_valid/out_ready/out/ovf - result channel (block -> consumer)
//           ovf_sticky/ovf_clear        - sticky overflow flag and its clear
// Modports: slave  - the subtractor block
//           master - the environment driving operands and consuming results
// ----------------------------------------------------------------------------
interface signed_subtractor_pipe_if #(
  parameter int IN1_WIDTH = 8,
  parameter int IN2_WIDTH = 8,
  parameter int OUT_WIDTH = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN1_WIDTH-1:0] a;
  logic signed [IN2_WIDTH-1:0] b;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out;
  logic                        ovf;
  logic                        ovf_sticky;
  logic                        ovf_clear;

  modport slave (
    input  in_valid, a, b, out_ready, ovf_clear,
    output in_ready, out_valid, out, ovf, ovf_sticky
  );

  modport master (
    output in_valid, a, b, out_ready, ovf_clear,
    input  in_ready, out_valid, out, ovf, ovf_sticky
  );
endinterface

// File: rtl/signed_subtractor_pipe.sv
// ----------------------------------------------------------------------------
// signed_subtractor_pipe
// Purpose : two-stage pipelined signed subtractor out = a - b with valid/ready
//           flow control on both sides and overflow reporting when the exact
//           difference does not fit OUT_WIDTH.
//           Stage 1 holds the exact difference (max(IN1,IN2)+1 bits).
//           Stage 2 holds the narrowed result and its overflow flag.
// Ports   : clk    - single clock, rising edge
//           resetn - asynchronous active-low reset
//           bus    - signed_subtractor_pipe_if.slave (operands, result,
//                    overflow flag, sticky overflow and its clear)
// Build   : define SIGNED_SUB_SAT_EN to saturate overflowing results;
//           otherwise the result wraps (low OUT_WIDTH bits). The ovf flag
//           behaves the same in both builds.
// ----------------------------------------------------------------------------
module signed_subtractor_pipe #(
  parameter int IN1_WIDTH = 8,
  parameter int IN2_WIDTH = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  signed_subtractor_pipe_if.slave  bus
);

  localparam int W = ((IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH) + 1;

  if (OUT_WIDTH < 2 || IN1_WIDTH < 1 || IN2_WIDTH < 1) begin : g_param_err
    $error("signed_subtractor_pipe: need OUT_WIDTH >= 2, IN1_WIDTH >= 1, IN2_WIDTH >= 1");
  end

  logic                        r_s1_valid;
  logic signed [W-1:0]         r_s1_d;
  logic                        r_s2_valid;
  logic signed [OUT_WIDTH-1:0] r_out;
  logic                        r_ovf;
  logic                        r_ovf_sticky;

  logic signed [W-1:0]         w_a_ext;
  logic signed [W-1:0]         w_b_ext;
  logic signed [W-1:0]         w_diff;
  logic signed [OUT_WIDTH-1:0] w_narrow;
  logic                        w_ovf;
  logic                        w_s2_load;
  logic                        w_s1_adv;
  logic                        w_in_xfer;
  logic                        w_out_xfer;

  // W is one bit wider than the widest operand, so the difference is exact.
  assign w_a_ext = {{(W-IN1_WIDTH){bus.a[IN1_WIDTH-1]}}, bus.a};
  assign w_b_ext = {{(W-IN2_WIDTH){bus.b[IN2_WIDTH-1]}}, bus.b};
  assign w_diff  = w_a_ext - w_b_ext;

  // Handshake: stage 2 accepts when empty or draining; stage 1 moves only
  // when it has something and stage 2 takes it. in_ready therefore depends
  // combinationally on out_ready.
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_load;
  assign bus.in_ready = !r_s1_valid || w_s1_adv;
  assign w_in_xfer  = bus.in_valid && bus.in_ready;
  assign w_out_xfer = r_s2_valid && bus.out_ready;

  if (OUT_WIDTH >= W) begin : g_wide
    // Result always fits: plain sign extension, no overflow possible.
    assign w_ovf    = 1'b0;
    assign w_narrow = OUT_WIDTH'(r_s1_d);
  end else begin : g_narrow
    // Fits iff all bits from the output sign bit upward are identical.
    logic [W-OUT_WIDTH:0] w_top;
    assign w_top = r_s1_d[W-1:OUT_WIDTH-1];
    assign w_ovf = !((&w_top) || !(|w_top));
`ifdef SIGNED_SUB_SAT_EN
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    assign w_narrow = w_ovf ? (r_s1_d[W-1] ? OUT_MIN : OUT_MAX)
                            : r_s1_d[OUT_WIDTH-1:0];
`else
    assign w_narrow = r_s1_d[OUT_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_d     <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_d     <= w_diff;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // When stage 2 loads from an empty stage 1 only the valid bit drops;
  // out/ovf keep their old values since they are qualified by out_valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_ovf      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out <= w_narrow;
        r_ovf <= w_ovf;
      end
    end
  end

  // Setting wins over a simultaneous clear so no overflow event is lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_out_xfer && r_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (bus.ovf_clear) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign bus.out_valid  = r_s2_valid;
  assign bus.out        = r_out;
  assign bus.ovf        = r_ovf;
  assign bus.ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_signed_subtractor_pipe.sv
module tb_signed_subtractor_pipe;

  localparam int WD = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  signed_subtractor_pipe_if #(.IN1_WIDTH(WD), .IN2_WIDTH(WD), .OUT_WIDTH(WD)) bus ();

  signed_subtractor_pipe #(.IN1_WIDTH(WD), .IN2_WIDTH(WD), .OUT_WIDTH(WD)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    int o;
    int v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  bit   sticky_exp = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_out = 0;
  int   prev_ovf = 0;

  // Reference: exact integer difference, then range check and wrap/clamp.
  function automatic exp_t model(int a, int b);
    exp_t e;
    int d;
    d   = a - b;
    e.v = (d > 127 || d < -128) ? 1 : 0;
`ifdef SIGNED_SUB_SAT_EN
    e.o = (d > 127) ? 127 : ((d < -128) ? -128 : d);
`else
    e.o = (((d + 128) % 256) + 256) % 256 - 128;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus side: record expected result for every accepted operand pair.
  always @(negedge clk) begin
    if (resetn && bus.in_valid && bus.in_ready) begin
      q.push_back(model(int'(bus.a), int'(bus.b)));
      n_pushed++;
    end
  end

  // Checking side: compare every result leaving the block, stall stability
  // and the sticky flag.
  always @(negedge clk) begin
    exp_t e;
    bit   xfer_ovf;
    if (!resetn) begin
      prev_stall = 1'b0;
      sticky_exp = 1'b0;
    end else begin
      chk("ovf_sticky", int'(bus.ovf_sticky), int'(sticky_exp));
      if (prev_stall) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_out", int'(bus.out), prev_out);
        chk("hold_ovf", int'(bus.ovf), prev_ovf);
      end
      xfer_ovf = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d expected=none at %0t", int'(bus.out), $time);
        end else begin
          e = q.pop_front();
          chk("out", int'(bus.out), e.o);
          chk("ovf", int'(bus.ovf), e.v);
          xfer_ovf = (e.v != 0);
        end
        n_popped++;
      end
      if (xfer_ovf) sticky_exp = 1'b1;
      else if (bus.ovf_clear) sticky_exp = 1'b0;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = int'(bus.out);
      prev_ovf   = int'(bus.ovf);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // One isolated item with out_ready high: checks latency and value.
  task automatic single(input int a, input int b, input int exp_o, input int exp_v, input string nm);
    bus.in_valid  = 1'b1;
    bus.a         = 8'(a);
    bus.b         = 8'(b);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    @(negedge clk);
    chk({nm, "_valid_early"}, int'(bus.out_valid), 0);
    step();
    @(negedge clk);
    chk({nm, "_valid"}, int'(bus.out_valid), 1);
    chk({nm, "_out"}, int'(bus.out), exp_o);
    chk({nm, "_ovf"}, int'(bus.ovf), exp_v);
    step();
  endtask

  initial begin
    int exp_seq[3];
    int idx;
    int start;
    int cyc;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clear = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_sticky", int'(bus.ovf_sticky), 0);
    chk("rst_out", int'(bus.out), 0);
    resetn = 1'b1;
    step();
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    step();

    // Basic and overflow corners
    single(5, 3, 2, 0, "sub_5_3");
`ifdef SIGNED_SUB_SAT_EN
    single(-128, 1, -128, 1, "sub_m128_1");
    single(127, -1, 127, 1, "sub_127_m1");
`else
    single(-128, 1, 127, 1, "sub_m128_1");
    single(127, -1, -128, 1, "sub_127_m1");
`endif
    single(-128, -128, 0, 0, "sub_m128_m128");
    single(-1, 127, -128, 0, "sub_m1_127");

    // Back-to-back with consumer stalled for three cycles
    exp_seq[0] = 0; exp_seq[1] = 7; exp_seq[2] = -4;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.a = 8'(1); bus.b = 8'(1);
    @(negedge clk); chk("b2b_rdy1", int'(bus.in_ready), 1);
    step();
    bus.a = 8'(9); bus.b = 8'(2);
    @(negedge clk); chk("b2b_rdy2", int'(bus.in_ready), 1);
    step();
    bus.a = 8'(0); bus.b = 8'(-4 + 4);
    bus.b = 8'(4);
    @(negedge clk); chk("b2b_full", int'(bus.in_ready), 0);
    step();
    bus.out_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) chk("b2b_rdy3", int'(bus.in_ready), 1);
      if (bus.out_valid && bus.out_ready && idx < 3) begin
        chk("b2b_order", int'(bus.out), exp_seq[idx]);
        idx++;
      end
      step();
      if (i == 0) bus.in_valid = 1'b0;
    end
    chk("b2b_count", idx, 3);

    // Reset with two items in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.a = 8'(20); bus.b = 8'(3);
    step();
    bus.a = 8'(-7); bus.b = 8'(8);
    step();
    bus.in_valid = 1'b0;
    chk("inflight_valid", int'(bus.out_valid), 1);
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.out_valid), 0);
    chk("async_rst_ovf", int'(bus.ovf), 0);
    q.delete();
    n_pushed = n_popped;
    step();
    step();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_ready", int'(bus.in_ready), 1);
      chk("post_rst_no_stale", int'(bus.out_valid), 0);
      step();
    end

    // Sticky set wins over simultaneous clear; clears a cycle later
    bus.ovf_clear = 1'b1;
    step();
    bus.ovf_clear = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.a = 8'(-128); bus.b = 8'(1);
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    chk("sticky_item_valid", int'(bus.out_valid), 1);
    chk("sticky_pre", int'(bus.ovf_sticky), 0);
    step();
    bus.out_ready = 1'b1;
    bus.ovf_clear = 1'b1;
    step();
    chk("sticky_set_wins", int'(bus.ovf_sticky), 1);
    step();
    chk("sticky_cleared", int'(bus.ovf_sticky), 0);
    bus.ovf_clear = 1'b0;

    // Random traffic
    start = n_pushed;
    cyc = 0;
    while ((n_pushed - start) < 10000 && cyc < 60000) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 99) < 70);
      bus.ovf_clear = ($urandom_range(0, 9) == 0);
      step();
      cyc++;
    end
    chk("random_items", int'((n_pushed - start) >= 10000), 1);

    // Drain
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clear = 1'b0;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    chk("drain_empty", q.size(), 0);
    chk("item_count", n_popped, n_pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_subtractor_pipe.md
SIGNED_SUBTRACTOR_PIPE -- requirements
Module: signed_subtractor_pipe

Interface
REQ-001 SHALL have parameter IN1_WIDTH, default 8, width of signed minuend a.
REQ-002 SHALL have parameter IN2_WIDTH, default 8, width of signed subtrahend b.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, width of signed result out.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  a/b valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a/b this cycle.
REQ-008 SHALL have port a  input  IN1_WIDTH  signed minuend.
REQ-009 SHALL have port b  input  IN2_WIDTH  signed subtrahend.
REQ-010 SHALL have port out_valid  output  1  out/ovf valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out.
REQ-012 SHALL have port out  output  OUT_WIDTH  signed result a - b.
REQ-013 SHALL have port ovf  output  1  out did not fit OUT_WIDTH; qualified by out_valid.
REQ-014 SHALL have port ovf_sticky  output  1  set on any overflow transferred at output.
REQ-015 SHALL have port ovf_clear  input  1  synchronous clear of ovf_sticky.

Function
REQ-016 SHALL transfer input on in_valid & in_ready and output on out_valid & out_ready.
REQ-017 SHALL compute D = a - b sign-extended to W = max(IN1_WIDTH, IN2_WIDTH) + 1 bits, exact.
REQ-018 SHALL be two register stages: S1 holds D; S2 holds narrowed out and ovf.
REQ-019 SHALL set ovf when D lies outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; never when OUT_WIDTH >= W.
REQ-020 SHALL present out_valid exactly 2 cycles after input transfer when out_ready is held high.
REQ-021 SHALL sustain one transfer per cycle with out_ready held high.
REQ-022 SHALL load S2 when S2 empty or out_ready; S1 advances when S1 valid and S2 loads.
REQ-023 SHALL drive in_ready = !S1_valid | S1 advancing (combinational from out_ready).
REQ-024 SHALL hold out, ovf and out_valid stable while out_valid & !out_ready.
REQ-025 SHALL preserve order; no item dropped or duplicated under any out_ready pattern.
REQ-026 SHALL ignore a/b when in_valid is low; in_valid may drop without a transfer.
REQ-027 SHALL set ovf_sticky when an ovf=1 item transfers at the output; set wins over simultaneous ovf_clear.
REQ-028 SHALL reject OUT_WIDTH < 2, IN1_WIDTH < 1 or IN2_WIDTH < 1 at elaboration.

Reset
REQ-029 SHALL clear S1_valid, S2_valid, out_valid, ovf and ovf_sticky immediately on resetn low; out SHALL reset to 0.
REQ-030 SHALL discard in-flight items on reset mid-operation; in_ready SHALL be 1 from the first edge after resetn rises.

Configuration
REQ-031 SHALL, with SIGNED_SUB_SAT_EN defined, clamp an overflowing D to 2^(OUT_WIDTH-1)-1 (positive) or -2^(OUT_WIDTH-1) (negative).
REQ-032 SHALL, without SIGNED_SUB_SAT_EN, set out to the low OUT_WIDTH bits of D (two's-complement wrap); ovf behaviour is identical in both builds.

Verification (all widths 8)
REQ-033 SHALL cover a=5, b=3, out_ready=1 -> out=2, ovf=0, out_valid exactly 2 cycles after transfer.
REQ-034 SHALL cover a=-128, b=1 -> ovf=1, out=127 (wrap) / -128 (sat); a=127, b=-1 -> out=-128 (wrap) / 127 (sat).
REQ-035 SHALL cover back-to-back inputs (1,1),(9,2),(0,4) with out_ready low 3 cycles -> in_ready=0 after 2 accepted; then outputs 0,7,-4 in order.
REQ-036 SHALL cover resetn pulsed low with 2 items in flight -> out_valid=0 at once, no stale output afterwards, in_ready=1.
REQ-037 SHALL cover ovf_clear asserted in the same cycle an ovf=1 item transfers -> ovf_sticky=1; ovf_clear the next cycle -> 0.
REQ-038 SHALL cover random valid/ready toggling over 10000 items against a reference model -> zero mismatches, zero loss.
